// File: rtl/ula_pkg.sv
// Shared definitions for the byte-serial 74181 sequencer.
//   BYTE_W          : ALU slice width in bits.
//   ula_seq_state_t : sequencer FSM states.
package ula_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } ula_seq_state_t;

endpackage

// File: rtl/ula_serial_ctrl.sv
// Byte-serial sequencer in front of an 8-bit 74181 ALU. Runs one operation on
// NBYTES-wide operands, one byte per cycle, LSB first, chaining alu_cout into
// the next byte's carry-in and assembling the wide result.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           request handshake
//   in_a, in_b                  wide operands (8*NBYTES)
//   in_s, in_m, in_cin          74181 select, mode, initial carry
//   alu_a, alu_b                current operand bytes (0 outside RUN)
//   alu_s, alu_m, alu_cin       latched select/mode, chained carry
//   alu_f, alu_cout, alu_a_eq_b ALU responses (combinational from alu_*)
//   out_valid/out_ready         result handshake
//   out_f, out_cout, out_a_eq_b assembled result, final carry, AND of equality flags
module ula_serial_ctrl
   import ula_pkg::*;
#(
   parameter int unsigned NBYTES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NBYTES*BYTE_W-1:0] in_a,
   input  logic [NBYTES*BYTE_W-1:0] in_b,
   input  logic [3:0]               in_s,
   input  logic                     in_m,
   input  logic                     in_cin,
   output logic [BYTE_W-1:0]        alu_a,
   output logic [BYTE_W-1:0]        alu_b,
   output logic [3:0]               alu_s,
   output logic                     alu_m,
   output logic                     alu_cin,
   input  logic [BYTE_W-1:0]        alu_f,
   input  logic                     alu_cout,
   input  logic                     alu_a_eq_b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NBYTES*BYTE_W-1:0] out_f,
   output logic                     out_cout,
   output logic                     out_a_eq_b
);

   localparam int unsigned W     = NBYTES * BYTE_W;
   localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   ula_seq_state_t   state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     result_q, result_d;
   logic [3:0]       s_q, s_d;
   logic             m_q, m_d;
   logic             carry_q, carry_d;
   logic             eq_q, eq_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         s_q      <= '0;
         m_q      <= 1'b0;
         carry_q  <= 1'b0;
         eq_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         s_q      <= s_d;
         m_q      <= m_d;
         carry_q  <= carry_d;
         eq_q     <= eq_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      s_d      = s_q;
      m_d      = m_q;
      carry_d  = carry_q;
      eq_d     = eq_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d      = in_a;
               b_d      = in_b;
               s_d      = in_s;
               m_d      = in_m;
               carry_d  = in_cin;
               idx_d    = '0;
               eq_d     = 1'b1;
               result_d = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            // Carry is chained in logic mode too; the ALU simply ignores it.
            result_d[idx_q*BYTE_W +: BYTE_W] = alu_f;
            carry_d = alu_cout;
            eq_d    = eq_q & alu_a_eq_b;
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      alu_s     = s_q;
      alu_m     = m_q;
      alu_a     = '0;
      alu_b     = '0;
      alu_cin   = 1'b0;
      if (state_q == RUN) begin
         alu_a   = a_q[idx_q*BYTE_W +: BYTE_W];
         alu_b   = b_q[idx_q*BYTE_W +: BYTE_W];
         alu_cin = carry_q;
      end
   end

   assign out_f      = result_q;
   assign out_cout   = carry_q;
   assign out_a_eq_b = eq_q;

endmodule

// File: tb/tb_ula_serial_ctrl.sv
// Directed bench for ula_serial_ctrl (NBYTES=4) paired with a behavioural ALU
// stub: arithmetic mode is f = a + b + cin; logic mode with s=0110 is a ^ b.
module tb_ula_serial_ctrl;

   localparam int unsigned NBYTES = 4;
   localparam int unsigned W      = NBYTES * 8;

   logic          clk, rst_n;
   logic          in_valid, in_ready;
   logic [W-1:0]  in_a, in_b;
   logic [3:0]    in_s;
   logic          in_m, in_cin;
   logic [7:0]    alu_a, alu_b, alu_f;
   logic [3:0]    alu_s;
   logic          alu_m, alu_cin, alu_cout, alu_a_eq_b;
   logic          out_valid, out_ready;
   logic [W-1:0]  out_f;
   logic          out_cout, out_a_eq_b;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   ula_serial_ctrl #(.NBYTES(NBYTES)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_s       (in_s),
      .in_m       (in_m),
      .in_cin     (in_cin),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_s      (alu_s),
      .alu_m      (alu_m),
      .alu_cin    (alu_cin),
      .alu_f      (alu_f),
      .alu_cout   (alu_cout),
      .alu_a_eq_b (alu_a_eq_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_f      (out_f),
      .out_cout   (out_cout),
      .out_a_eq_b (out_a_eq_b)
   );

   // ALU stub
   logic [8:0] stub_sum;
   always_comb begin
      stub_sum   = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      alu_cout   = stub_sum[8];
      alu_a_eq_b = (alu_a == alu_b);
      if (alu_m && alu_s == 4'b0110) alu_f = alu_a ^ alu_b;
      else                           alu_f = stub_sum[7:0];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request at a falling edge; returns at the falling edge after the accept edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                           input logic m, input logic cin);
      in_a = a; in_b = b; in_s = s; in_m = m; in_cin = cin;
      in_valid = 1'b1;
      check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_a = $urandom; in_b = $urandom; // buses are don't-care while busy
   endtask

   // Counts clock edges from accept until out_valid, bounded.
   task automatic wait_done(input string tag);
      int n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(n), 64'(NBYTES));
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_after_handshake_in_ready", {63'd0, in_ready}, 64'd1);
      check("idle_after_handshake_out_valid", {63'd0, out_valid}, 64'd0);
   endtask

   logic [W-1:0] ra [21];
   logic [W-1:0] rb [21];
   logic         rc [21];
   logic [W:0]   exp_sum;
   logic         seen_valid;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_s = '0; in_m = 1'b0; in_cin = 1'b0;
      #2;
      check("rst_in_ready",   {63'd0, in_ready},   64'd1);
      check("rst_out_valid",  {63'd0, out_valid},  64'd0);
      check("rst_out_f",      64'(out_f),          64'd0);
      check("rst_out_cout",   {63'd0, out_cout},   64'd0);
      check("rst_out_eq",     {63'd0, out_a_eq_b}, 64'd0);
      check("rst_alu_a",      64'(alu_a),          64'd0);
      check("rst_alu_b",      64'(alu_b),          64'd0);
      check("rst_alu_s",      64'(alu_s),          64'd0);
      check("rst_alu_m_cin",  {62'd0, alu_m, alu_cin}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset mid-RUN abandons the operation.
      start_op(32'h1111_1111, 32'h2222_2222, 4'b1001, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrun_rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("midrun_rst_alu_a", 64'(alu_a), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen_valid |= out_valid;
      end
      check("midrun_rst_no_out_valid", {63'd0, seen_valid}, 64'd0);

      // Carry chain
      start_op(32'h00FF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0);
      wait_done("carry1_latency");
      check("carry1_f",    64'(out_f),        64'h0100_0000);
      check("carry1_cout", {63'd0, out_cout}, 64'd0);
      finish_op();
      @(negedge clk);
      start_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0);
      wait_done("carry2_latency");
      check("carry2_f",    64'(out_f),        64'h0);
      check("carry2_cout", {63'd0, out_cout}, 64'd1);
      finish_op();
      @(negedge clk);

      // Logic XOR
      start_op(32'h1234_5678, 32'hFFFF_0000, 4'b0110, 1'b1, 1'b0);
      check("xor_alu_m", {63'd0, alu_m}, 64'd1);
      check("xor_alu_s", 64'(alu_s), 64'h6);
      wait_done("xor_latency");
      check("xor_f", 64'(out_f), 64'hEDCB_5678);
      finish_op();
      @(negedge clk);

      // Equality
      start_op(32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'b1001, 1'b0, 1'b0);
      wait_done("eq1_latency");
      check("eq1_flag", {63'd0, out_a_eq_b}, 64'd1);
      check("eq1_f", 64'(out_f), 64'h4B4B_4B4A);
      finish_op();
      @(negedge clk);
      start_op(32'hA5A5_A5A5, 32'hA55A_A5A5, 4'b1001, 1'b0, 1'b0);
      wait_done("eq2_latency");
      check("eq2_flag", {63'd0, out_a_eq_b}, 64'd0);

      // Backpressure: held in DONE, inputs ignored.
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_a = $urandom; in_b = $urandom;
         @(negedge clk);
         check("bp_out_valid", {63'd0, out_valid}, 64'd1);
         check("bp_in_ready",  {63'd0, in_ready},  64'd0);
         check("bp_out_f",     64'(out_f),         64'h4B00_4B4A);
      end
      in_valid = 1'b0;
      finish_op();
      start_op(32'h0000_0010, 32'h0000_0020, 4'b1001, 1'b0, 1'b1);
      check("bp_accept_in_ready", {63'd0, in_ready}, 64'd0);
      wait_done("bp_next_latency");
      check("bp_next_f", 64'(out_f), 64'h31);
      finish_op();
      @(negedge clk);

      // Back-to-back with in_valid and out_ready held high.
      for (int k = 0; k < 21; k++) begin
         ra[k] = $urandom;
         rb[k] = (k % 5 == 0) ? ra[k] : $urandom;
         rc[k] = 1'($urandom_range(0, 1));
      end
      in_a = ra[0]; in_b = rb[0]; in_cin = rc[0]; in_s = 4'b1001; in_m = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         in_a = ra[k+1]; in_b = rb[k+1]; in_cin = rc[k+1];
         exp_sum = {1'b0, ra[k]} + {1'b0, rb[k]} + {{W{1'b0}}, rc[k]};
         for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j == 3) check("b2b_not_early", {63'd0, out_valid}, 64'd0);
            if (j == 4) begin
               check("b2b_valid", {63'd0, out_valid}, 64'd1);
               check("b2b_f",     64'(out_f),         64'(exp_sum[W-1:0]));
               check("b2b_cout",  {63'd0, out_cout},  {63'd0, exp_sum[W]});
               check("b2b_eq",    {63'd0, out_a_eq_b}, {63'd0, ra[k] == rb[k]});
            end
            if (j == 5) begin
               check("b2b_idle_in_ready", {63'd0, in_ready}, 64'd1);
               if (k == 19) in_valid = 1'b0;
            end
         end
      end
      out_ready = 1'b0;
      @(negedge clk);
      check("final_idle", {63'd0, in_ready}, 64'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ula_serial_ctrl.md
# ula_serial_ctrl

Byte-serial sequencer that sits directly upstream of the 8-bit 74181 ALU (`ula_8bits`). It executes one operation on wide operands (NBYTES × 8 bits) by issuing one byte per cycle to the ALU, least-significant byte first. It chains the ALU carry-out back into the next byte's carry-in and assembles the wide result. Operand and result transfers use valid/ready handshakes.

## Interface
- NBYTES, default 4: operand width in bytes; legal range 2..8.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request present.
- in_ready  out  1  block can accept a request.
- in_a, in_b  in  8*NBYTES  operands.
- in_s  in  4  74181 select.
- in_m  in  1  mode: 0 = arithmetic, 1 = logic.
- in_cin  in  1  initial carry-in.
- alu_a, alu_b  out  8  current byte, driven to the ALU.
- alu_s  out  4  latched select, driven to the ALU.
- alu_m  out  1  latched mode, driven to the ALU.
- alu_cin  out  1  chained carry, driven to the ALU.
- alu_f  in  8  ALU result (combinational from alu_*).
- alu_cout  in  1  ALU carry-out.
- alu_a_eq_b  in  1  ALU equality flag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_f  out  8*NBYTES  assembled result.
- out_cout  out  1  carry-out of the most-significant byte.
- out_a_eq_b  out  1  AND of all per-byte equality flags.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a, in_b, in_s, in_m; set carry_reg=in_cin, idx=0, eq_reg=1, result=0; go to RUN.
- RUN:
  - alu_a = a_reg byte[idx]; alu_b = b_reg byte[idx]; alu_cin = carry_reg.
  - Each edge: result byte[idx] <= alu_f; carry_reg <= alu_cout; eq_reg <= eq_reg & alu_a_eq_b.
  - If idx == NBYTES-1, go to DONE; otherwise idx++.
  - idx width is $clog2(NBYTES); it never wraps past NBYTES-1.
- DONE:
  - out_valid=1.
  - out_f = result, out_cout = carry_reg, out_a_eq_b = eq_reg, all held stable.
  - On out_ready, go to IDLE.
- alu_s and alu_m always reflect the latched operation. alu_a and alu_b are 0 outside RUN.
- Carry is chained identically in logic mode (m=1). The ALU ignores it, and out_cout reports the last alu_cout unchanged.
- in_ready=0 in RUN and DONE. in_valid is ignored there, and the input buses may change freely.
- out_ready outside DONE has no effect.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, in_ready=1, out_valid=0.
  - out_f=0, out_cout=0, out_a_eq_b=0.
  - alu_a=alu_b=0, alu_s=0, alu_m=0, alu_cin=0.
- Latency: request accepted at edge T. RUN occupies cycles T..T+NBYTES-1. out_valid rises after edge T+NBYTES.
- Throughput: with out_ready held at 1, one operation per NBYTES+2 cycles.
  - The IDLE cycle after DONE is mandatory.
  - No accept happens in the same cycle as the out handshake.
- Backpressure: DONE is held indefinitely while out_ready=0. Outputs do not change.
- Reset asserted mid-RUN or mid-DONE: the operation is abandoned, no out_valid is produced, and the FSM restarts in IDLE after release.
- in_valid and out_ready are sampled only on rising edges. Glitches between edges are irrelevant.

## Structure
- Shared package `ula_pkg`:
  - localparam BYTE_W=8.
  - typedef enum logic [1:0] {IDLE, RUN, DONE} ula_seq_state_t.
- No sub-module is required. The byte-select mux and the result byte write are inline.
- Top-level integration connects alu_* to one `ula_8bits` instance.
- The bench pairs the block with either `ula_8bits` or a behavioural adder stub: f = a + b + cin, cout = carry out of bit 7, a_eq_b = (a==b).

## Test plan
- Reset: with rst_n=0 → in_ready=1, out_valid=0, out_f=0, alu_a=0. Then assert rst_n=0 mid-RUN → out_valid never rises; the next request completes normally.
- Carry chain (stub, NBYTES=4): a=0x00FF_FFFF, b=0x0000_0001, cin=0 → out_f=0x0100_0000, out_cout=0. Then a=0xFFFF_FFFF, b=1 → out_f=0, out_cout=1.
- Logic XOR (`ula_8bits`, s=0110, m=1): a=0x1234_5678, b=0xFFFF_0000 → out_f=0xEDCB_5678 after exactly NBYTES edges past accept.
- Equality: stub with a=b=0xA5A5_A5A5 → out_a_eq_b=1. Change only byte 2 of b → out_a_eq_b=0.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid and out_f stable, in_ready=0, in_valid ignored. Then pulse out_ready → IDLE next cycle, and a new request is accepted on the following edge.
- Back-to-back: 20 random requests with in_valid and out_ready held at 1 → one result every NBYTES+2 cycles, each result matching the reference model.
